bus_grant_controller: RTL and testbench
=======================================

// Module: bus_grant_controller
// PURPOSE
//  Sequences ownership of the shared snooping bus between N_CACHE cache controllers and the memory controller.
//  Registered round-robin arbitration; the grant is held for a whole transaction, not rotated every cycle.
//  Memory is granted only when no cache requests. A one-cycle turnaround separates owners.
//  Sits between the per-core cache controllers and the bus mux select logic.
// PARAMETERS
//  N_CACHE    4   number of cache requesters (>=2)
//  HOLD_MAX   16  max cycles one owner may hold the bus (watchdog; used only with BUS_TIMEOUT_EN)
// PORTS
//  clk          in   1                      single clock, rising edge
//  rst_n        in   1                      asynchronous active-low reset
//  req          in   N_CACHE                cache bus requests, level, held until done
//  mem_req      in   1                      memory controller bus request, level
//  done         in   1                      1-cycle pulse from current owner: transaction complete
//  gnt          out  N_CACHE                one-hot cache grant, registered
//  mem_gnt      out  1                      memory grant, registered
//  bus_busy     out  1                      1 while any grant is high
//  owner_id     out  $clog2(N_CACHE+1)      current owner; N_CACHE = memory; 0 when idle
//  timeout_err  out  1                      1-cycle pulse when watchdog revokes a grant
// BEHAVIOUR
//  Reset (async, rst_n=0): every output goes to 0 immediately. state=IDLE, rr_ptr=0, hold_cnt=0.
//  FSM: IDLE -> OWN -> TURN -> IDLE.
//  IDLE
//   - Sample req/mem_req. Winner = first asserted req at index rr_ptr, rr_ptr+1, ... mod N_CACHE.
//   - If no req is set and mem_req=1, the winner is memory.
//   - On the edge, the winner's grant goes high, owner_id loads, and state moves to OWN.
//   - Latency: req high before edge k -> gnt high after edge k.
//   - No request: stay IDLE, all grants 0.
//  OWN
//   - Grant held; hold_cnt increments each cycle.
//   - Exit to TURN on any of: done=1; the owner's own request drops; hold_cnt==HOLD_MAX-1 (timeout, option only).
//   - On the exit edge: all grants go 0, and owner_id is held until IDLE.
//   - A cache winner sets rr_ptr=(winner+1)%N_CACHE on exit. A memory win leaves rr_ptr unchanged.
//  TURN
//   - Exactly one cycle with every grant low, then IDLE.
//   - owner_id clears to 0 on entry to IDLE.
//   - Back-to-back owner changes therefore take at least 3 cycles: OWN, TURN, IDLE-eval.
//  Boundaries
//   - Requests from non-owners during OWN or TURN are ignored and never latched; a requester must hold req.
//   - done and timeout in the same cycle: treated as done, no timeout_err.
//   - done while in IDLE or TURN: ignored.
//   - rr_ptr wraps from N_CACHE-1 to 0.
//   - The same cache wins again only if no other cache requests.
//   - Grants are one-hot or zero at all times; gnt and mem_gnt are never high together.
//   - Reset mid-OWN: grants drop asynchronously, no timeout_err. Arbitration restarts with rr_ptr=0.
// CONFIGURATION
//  BUS_TIMEOUT_EN defined
//   - hold_cnt watchdog is active.
//   - Revocation at HOLD_MAX cycles of ownership pulses timeout_err for 1 cycle, coincident with grant drop.
//   - Then TURN as normal.
//  BUS_TIMEOUT_EN undefined
//   - No hold_cnt and no timeout; an owner holds the bus until done or its request drops.
//   - timeout_err is tied to 0.
// STRUCTURE
//  Package bus_arb_pkg
//   - typedef enum logic [1:0] {IDLE, OWN, TURN} bus_state_e.
//   - Constants N_CACHE_DEF=4 and HOLD_MAX_DEF=16.
//   - owner_t typedef; MEM_ID=N_CACHE.
//  Sub-module rr_priority_pick (combinational)
//   - Inputs: req vector, rr_ptr.
//   - Outputs: one-hot pick, pick index, any.
//   - Implemented as a rotate, then fixed-priority pick, then rotate back.
//  Top level: FSM, rr_ptr, hold_cnt, registered grants.
// TESTING
//  1. Reset, then req=4'b0110.
//     -> gnt=4'b0010 one cycle later, owner_id=1.
//     -> done pulse -> gnt=0 for TURN -> gnt=4'b0100 (rr_ptr=2).
//  2. All four reqs held with done every 3rd OWN cycle.
//     -> grant order 0,1,2,3,0.
//     -> never two grants at once; a 1-cycle gap between owners.
//  3. mem_req=1 with req=0 -> mem_gnt=1, owner_id=4.
//     mem_req=1 with req=4'b1000 -> gnt=4'b1000, mem_gnt stays 0 until no cache request.
//  4. With BUS_TIMEOUT_EN, HOLD_MAX=16, owner never sends done.
//     -> grant drops after 16 OWN cycles with timeout_err=1 for one cycle.
//     -> same cycle with done=1 -> no error.
//  5. Owner drops req mid-OWN -> grant drops next edge, no timeout_err.
//     rst_n=0 mid-OWN -> gnt=0 immediately; next win starts from index 0.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the snooping-bus grant controller.
package bus_arb_pkg;

  localparam int N_CACHE_DEF  = 4;
  localparam int HOLD_MAX_DEF = 16;

  // Owner encoding: 0..N_CACHE-1 are caches, N_CACHE is the memory controller.
  localparam int MEM_ID = N_CACHE_DEF;

  typedef logic [$clog2(N_CACHE_DEF+1)-1:0] owner_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } bus_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin picker: rotate the request vector so rr_ptr sits at bit 0,
// take the lowest set bit, then rotate the one-hot result back.
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  pick,
  output logic [PW-1:0] pick_idx,
  output logic          any
);

  logic [2*N-1:0] dbl_req;
  logic [N-1:0]   rot_req;
  logic [N-1:0]   rot_pick;
  logic [2*N-1:0] dbl_pick;
  int             rot_idx;
  int             abs_idx;

  // Rotate, fixed-priority select, rotate back.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    rot_pick = '0;
    rot_idx  = 0;
    dbl_req  = {req, req} >> rr_ptr;
    rot_req  = dbl_req[N-1:0];
    // Descending scan: the last hit is the lowest index, i.e. closest to rr_ptr.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        rot_pick    = '0;
        rot_pick[i] = 1'b1;
        rot_idx     = i;
      end
    end
    dbl_pick = {rot_pick, rot_pick} << rr_ptr;
    pick     = dbl_pick[2*N-1:N];
    abs_idx  = rot_idx + int'(rr_ptr);
    if (abs_idx >= N) abs_idx = abs_idx - N;
    pick_idx = PW'(abs_idx);
    any      = |req;
  end

endmodule

// File: rtl/bus_grant_controller.sv
// Snooping-bus grant controller: registered round-robin arbitration among the
// cache controllers, memory granted only when no cache requests, grant held for
// a whole transaction, one turnaround cycle between owners.
// Optional hold watchdog enabled by defining BUS_TIMEOUT_EN.
module bus_grant_controller
  import bus_arb_pkg::*;
#(
  parameter int N_CACHE  = N_CACHE_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_CACHE-1:0]             req,
  input  logic                           mem_req,
  input  logic                           done,
  output logic [N_CACHE-1:0]             gnt,
  output logic                           mem_gnt,
  output logic                           bus_busy,
  output logic [$clog2(N_CACHE+1)-1:0]   owner_id,
  output logic                           timeout_err
);

  localparam int PW = $clog2(N_CACHE);
  localparam int OW = $clog2(N_CACHE+1);

  bus_state_e         state, state_d;
  logic [PW-1:0]      rr_ptr, rr_ptr_d;
  logic [N_CACHE-1:0] gnt_d;
  logic               mem_gnt_d;
  logic [OW-1:0]      owner_d;
  logic               timeout_d;

  logic [N_CACHE-1:0] pick;
  logic [PW-1:0]      pick_idx;
  logic               pick_any;
  logic               owner_req;
  logic               hold_expired;

`ifdef BUS_TIMEOUT_EN
  localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  logic [HW-1:0] hold_cnt, hold_cnt_d;
  assign hold_expired = (hold_cnt == HW'(HOLD_MAX - 1));
`else
  assign hold_expired = 1'b0;
`endif

  rr_priority_pick #(
    .N  (N_CACHE),
    .PW (PW)
  ) u_pick (
    .req      (req),
    .rr_ptr   (rr_ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  // The current owner's own request line; dropping it ends the transaction.
  assign owner_req = mem_gnt ? mem_req : |(req & gnt);
  assign bus_busy  = (|gnt) | mem_gnt;

  // Next-state and next-output decode for the IDLE/OWN/TURN sequence.
  always_comb begin
    state_d   = state;
    rr_ptr_d  = rr_ptr;
    gnt_d     = gnt;
    mem_gnt_d = mem_gnt;
    owner_d   = owner_id;
    timeout_d = 1'b0;
`ifdef BUS_TIMEOUT_EN
    hold_cnt_d = hold_cnt;
`endif
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick;
          owner_d = OW'(pick_idx);
          state_d = OWN;
        end else if (mem_req) begin
          mem_gnt_d = 1'b1;
          owner_d   = OW'(N_CACHE);
          state_d   = OWN;
        end
`ifdef BUS_TIMEOUT_EN
        hold_cnt_d = '0;
`endif
      end
      OWN: begin
`ifdef BUS_TIMEOUT_EN
        hold_cnt_d = hold_cnt + 1'b1;
`endif
        if (done || !owner_req || hold_expired) begin
          gnt_d     = '0;
          mem_gnt_d = 1'b0;
          state_d   = TURN;
          // A coincident done wins over the watchdog: the owner finished cleanly.
          timeout_d = hold_expired && !done;
`ifdef BUS_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
          if (!mem_gnt) begin
            rr_ptr_d = (owner_id == OW'(N_CACHE - 1)) ? '0 : PW'(owner_id + OW'(1));
          end
        end
      end
      TURN: begin
        state_d = IDLE;
        owner_d = '0;
      end
      default: begin
        state_d   = IDLE;
        gnt_d     = '0;
        mem_gnt_d = 1'b0;
        owner_d   = '0;
      end
    endcase
  end

  // State, pointer and registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      gnt         <= '0;
      mem_gnt     <= 1'b0;
      owner_id    <= '0;
      timeout_err <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      hold_cnt    <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state       <= state_d;
      rr_ptr      <= rr_ptr_d;
      gnt         <= gnt_d;
      mem_gnt     <= mem_gnt_d;
      owner_id    <= owner_d;
      timeout_err <= timeout_d;
`ifdef BUS_TIMEOUT_EN
      hold_cnt    <= hold_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_bus_grant_controller.sv
// Self-checking bench for bus_grant_controller: directed scenarios plus a
// randomized run against a transaction-level ownership model.
module tb_bus_grant_controller;

  localparam int N        = 4;
  localparam int HOLD_MAX = 16;
  localparam int OW       = 3;
`ifdef BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic          mem_req;
  logic          done;
  logic [N-1:0]  gnt;
  logic          mem_gnt;
  logic          bus_busy;
  logic [OW-1:0] owner_id;
  logic          timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  bus_grant_controller #(
    .N_CACHE  (N),
    .HOLD_MAX (HOLD_MAX)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .mem_req     (mem_req),
    .done        (done),
    .gnt         (gnt),
    .mem_gnt     (mem_gnt),
    .bus_busy    (bus_busy),
    .owner_id    (owner_id),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  wire [N+OW+2:0] dut_bus = {gnt, mem_gnt, bus_busy, owner_id, timeout_err};

  // Reference model: who owns the bus, whether we are in the turnaround gap,
  // where round-robin search starts, and how long the owner has held it.
  bit m_active, m_turn, m_tout;
  int m_owner, m_ptr, m_held;

  function automatic void model_reset();
    m_active = 0; m_turn = 0; m_tout = 0;
    m_owner  = 0; m_ptr  = 0; m_held = 0;
  endfunction

  function automatic void model_step();
    int  w;
    bit  still, to;
    m_tout = 0;
    if (m_turn) begin
      m_turn = 0;
    end else if (m_active) begin
      m_held++;
      still = (m_owner == N) ? mem_req : req[m_owner];
      to    = TO_EN && (m_held >= HOLD_MAX);
      if (done || !still || to) begin
        m_active = 0;
        m_turn   = 1;
        m_tout   = to && !done;
        if (m_owner < N) m_ptr = (m_owner + 1) % N;
      end
    end else begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w < 0 && mem_req) w = N;
      if (w >= 0) begin
        m_active = 1;
        m_owner  = w;
        m_held   = 0;
      end
    end
  endfunction

  function automatic logic [N+OW+2:0] exp_bus();
    logic [N-1:0] g;
    g = '0;
    if (m_active && m_owner < N) g[m_owner] = 1'b1;
    return {g, (m_active && m_owner == N), m_active,
            (m_active || m_turn) ? OW'(m_owner) : OW'(0), m_tout};
  endfunction

  // Advance one clock; model follows the same sampled inputs; settle after edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic settle();
    req = '0; mem_req = 0; done = 0;
    repeat (3) step();
  endtask

  task automatic do_reset();
    rst_n = 0; req = '0; mem_req = 0; done = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; req = 4'b1111; mem_req = 1; done = 0;
    model_reset();
    #1;
    n_checks++;
    if (dut_bus !== '0) $display("FAIL reset_outputs: got %h expected 0", dut_bus);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (dut_bus !== '0) $display("FAIL reset_held: got %h expected 0", dut_bus);
    else n_pass++;
    req = '0; mem_req = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_basic();
    req = 4'b0110;
    step();
    n_checks++;
    if (gnt !== 4'b0010 || owner_id !== 3'd1)
      $display("FAIL basic_first_win: gnt=%b owner=%0d expected 0010/1", gnt, owner_id);
    else n_pass++;
    done = 1;
    step();
    done = 0;
    n_checks++;
    if (gnt !== 4'b0000 || owner_id !== 3'd1 || bus_busy !== 1'b0)
      $display("FAIL basic_turn: gnt=%b owner=%0d busy=%b expected 0000/1/0", gnt, owner_id, bus_busy);
    else n_pass++;
    step();
    n_checks++;
    if (gnt !== 4'b0000 || owner_id !== 3'd0)
      $display("FAIL basic_idle: gnt=%b owner=%0d expected 0000/0", gnt, owner_id);
    else n_pass++;
    step();
    n_checks++;
    if (gnt !== 4'b0100 || owner_id !== 3'd2)
      $display("FAIL basic_rotate: gnt=%b owner=%0d expected 0100/2", gnt, owner_id);
    else n_pass++;
    settle();
  endtask

  task automatic test_rotation();
    int order[5];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int nrec = 0;
    int own  = 0;
    int errs = 0;
    do_reset();
    req = 4'b1111;
    for (int cyc = 0; cyc < 80 && nrec < 5; cyc++) begin
      step();
      done = 0;
      if (dut_bus !== exp_bus() || !$onehot0({gnt, mem_gnt})) errs++;
      if (gnt != '0) begin
        own++;
        if (own == 1)
          for (int b = 0; b < N; b++) if (gnt[b]) order[nrec] = b;
        if (own == 1) nrec++;
        if (own == 3) done = 1;
      end else begin
        own = 0;
      end
    end
    n_checks++;
    if (errs != 0) $display("FAIL rotation_cycles: %0d cycle errors, expected 0", errs);
    else n_pass++;
    n_checks++;
    if (nrec != 5) $display("FAIL rotation_count: got %0d grants, expected 5", nrec);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i < nrec && order[i] != exp_order[i])
        $display("FAIL rotation_order[%0d]: got %0d expected %0d", i, order[i], exp_order[i]);
      else n_pass++;
    end
    done = 0;
    settle();
  endtask

  task automatic test_memory();
    mem_req = 1;
    step();
    n_checks++;
    if (mem_gnt !== 1'b1 || gnt !== 4'b0000 || owner_id !== 3'd4)
      $display("FAIL mem_win: mem_gnt=%b gnt=%b owner=%0d expected 1/0000/4", mem_gnt, gnt, owner_id);
    else n_pass++;
    req = 4'b1000;
    step();
    n_checks++;
    if (dut_bus !== exp_bus()) $display("FAIL mem_hold: got %h expected %h", dut_bus, exp_bus());
    else n_pass++;
    mem_req = 0;
    step();
    mem_req = 1;
    step();
    step();
    n_checks++;
    if (gnt !== 4'b1000 || mem_gnt !== 1'b0)
      $display("FAIL mem_cache_priority: gnt=%b mem_gnt=%b expected 1000/0", gnt, mem_gnt);
    else n_pass++;
    done = 1;
    step();
    done = 0;
    repeat (2) step();
    n_checks++;
    if (gnt !== 4'b1000 || mem_gnt !== 1'b0)
      $display("FAIL mem_same_cache_again: gnt=%b mem_gnt=%b expected 1000/0", gnt, mem_gnt);
    else n_pass++;
    req = '0;
    repeat (3) step();
    n_checks++;
    if (dut_bus !== exp_bus() || mem_gnt !== 1'b1)
      $display("FAIL mem_after_cache: got %h expected %h", dut_bus, exp_bus());
    else n_pass++;
    settle();
  endtask

  task automatic test_timeout();
    int own = 0;
    int errs = 0;
    bit seen_err = 0;
    req = 4'b0001;
    step();
    own = 1;
    for (int g = 0; g < 40; g++) begin
      step();
      if (dut_bus !== exp_bus()) errs++;
      if (timeout_err) seen_err = 1;
      if (gnt == '0) break;
      own++;
    end
    n_checks++;
    if (errs != 0) $display("FAIL hold_cycles: %0d cycle errors, expected 0", errs);
    else n_pass++;
    if (TO_EN) begin
      n_checks++;
      if (own != HOLD_MAX || timeout_err !== 1'b1)
        $display("FAIL timeout_revoke: held %0d err=%b expected %0d/1", own, timeout_err, HOLD_MAX);
      else n_pass++;
      step();
      n_checks++;
      if (timeout_err !== 1'b0) $display("FAIL timeout_pulse_width: err=%b expected 0", timeout_err);
      else n_pass++;
      settle();
      req = 4'b0001;
      step();
      repeat (HOLD_MAX - 1) step();
      done = 1;
      step();
      done = 0;
      n_checks++;
      if (gnt !== 4'b0000 || timeout_err !== 1'b0)
        $display("FAIL timeout_vs_done: gnt=%b err=%b expected 0000/0", gnt, timeout_err);
      else n_pass++;
    end else begin
      n_checks++;
      if (gnt !== 4'b0001 || seen_err)
        $display("FAIL no_timeout_hold: gnt=%b err_seen=%b expected 0001/0", gnt, seen_err);
      else n_pass++;
    end
    settle();
  endtask

  task automatic test_req_drop();
    req = 4'b0100;
    step();
    repeat (2) step();
    req = '0;
    step();
    n_checks++;
    if (gnt !== 4'b0000 || bus_busy !== 1'b0 || timeout_err !== 1'b0)
      $display("FAIL req_drop: gnt=%b busy=%b err=%b expected 0000/0/0", gnt, bus_busy, timeout_err);
    else n_pass++;
    settle();
  endtask

  task automatic test_reset_mid_own();
    req = 4'b0100;
    step();
    step();
    #2;
    rst_n = 0;
    model_reset();
    #1;
    n_checks++;
    if (dut_bus !== '0) $display("FAIL reset_mid_own: got %h expected 0", dut_bus);
    else n_pass++;
    req = 4'b1111;
    @(negedge clk);
    rst_n = 1;
    step();
    n_checks++;
    if (gnt !== 4'b0001 || owner_id !== 3'd0)
      $display("FAIL reset_rr_restart: gnt=%b owner=%0d expected 0001/0", gnt, owner_id);
    else n_pass++;
    settle();
  endtask

  task automatic test_random();
    int errs = 0;
    int grants = 0;
    for (int c = 0; c < 400; c++) begin
      req     = req ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      mem_req = ($urandom_range(0, 3) == 0) ? ~mem_req : mem_req;
      done    = ($urandom_range(0, 4) == 0);
      step();
      if (bus_busy) grants++;
      if (dut_bus !== exp_bus() || !$onehot0({gnt, mem_gnt})) begin
        errs++;
        if (errs <= 5) $display("FAIL random_cycle %0d: got %h expected %h", c, dut_bus, exp_bus());
      end
    end
    n_checks++;
    if (errs != 0 || grants == 0)
      $display("FAIL random_total: %0d errors, %0d busy cycles", errs, grants);
    else n_pass++;
    done = 0;
    settle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rotation();
    test_memory();
    test_timeout();
    test_req_drop();
    test_reset_mid_own();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
